// File: rtl/if_prefetch_queue_if.sv
// Instruction-memory request/response bus: in-order req/gnt issue, rvalid/rdata return.
interface if_prefetch_queue_if #(
    parameter int WORD_LEN = 32
);
    logic                req;
    logic [WORD_LEN-1:0] addr;
    logic                gnt;
    logic                rvalid;
    logic [WORD_LEN-1:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/if_prefetch_queue.sv
// Fetch stage: credit-limited in-order instruction prefetch into a small FIFO,
// with branch redirect flushing the FIFO and discarding responses still in flight.
module if_prefetch_queue #(
    parameter int                  WORD_LEN = 32,
    parameter int                  DEPTH    = 4,
    parameter logic [WORD_LEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hazard_detected_i,
    input  logic                Br_Taken_ID_i,
    input  logic [WORD_LEN-1:0] Br_addr_ID_i,
    if_prefetch_queue_if.master imem,
    output logic [WORD_LEN-1:0] PC_IF_o,
    output logic [WORD_LEN-1:0] inst_IF_o,
    output logic                IF_valid_o,
    output logic                IF_Flush_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0]       count_q, count_d, in_flight_q, in_flight_d, discard_q, discard_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [WORD_LEN-1:0] fetch_pc_q, fetch_pc_d, ret_pc_q, ret_pc_d;
    logic                flush_q;
    logic [WORD_LEN-1:0] pc_mem_q   [DEPTH];
    logic [WORD_LEN-1:0] inst_mem_q [DEPTH];

    logic [CW:0] used;
    logic        gnt_acc, push, pop, rsp_drop;

    // Buffered words plus outstanding requests never exceed DEPTH, so a push always has room.
    assign used       = {1'b0, count_q} + {1'b0, in_flight_q};
    assign imem.req   = rst && !Br_Taken_ID_i && (used < (CW+1)'(DEPTH));
    assign imem.addr  = fetch_pc_q;

    assign IF_valid_o = (count_q != '0) && !Br_Taken_ID_i;
    assign PC_IF_o    = pc_mem_q[rd_ptr_q];
    assign inst_IF_o  = inst_mem_q[rd_ptr_q];
    assign IF_Flush_o = flush_q;

    assign gnt_acc  = imem.req && imem.gnt;
    assign rsp_drop = imem.rvalid && (discard_q != '0);
    assign push     = imem.rvalid && (discard_q == '0) && !Br_Taken_ID_i;
    assign pop      = IF_valid_o && !hazard_detected_i;

    always_comb begin
        in_flight_d = in_flight_q + CW'(gnt_acc) - CW'(imem.rvalid);
        count_d     = count_q + CW'(push) - CW'(pop);
        rd_ptr_d    = rd_ptr_q + AW'(pop);
        wr_ptr_d    = wr_ptr_q + AW'(push);
        fetch_pc_d  = gnt_acc ? fetch_pc_q + WORD_LEN'(4) : fetch_pc_q;
        ret_pc_d    = push ? ret_pc_q + WORD_LEN'(4) : ret_pc_q;
        discard_d   = discard_q - CW'(rsp_drop);
        if (Br_Taken_ID_i) begin
            // Everything still outstanding after this cycle belongs to the old stream.
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fetch_pc_d = Br_addr_ID_i;
            ret_pc_d   = Br_addr_ID_i;
            discard_d  = in_flight_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q     <= '0;
            in_flight_q <= '0;
            discard_q   <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            fetch_pc_q  <= RESET_PC;
            ret_pc_q    <= RESET_PC;
            flush_q     <= 1'b0;
        end else begin
            count_q     <= count_d;
            in_flight_q <= in_flight_d;
            discard_q   <= discard_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            fetch_pc_q  <= fetch_pc_d;
            ret_pc_q    <= ret_pc_d;
            flush_q     <= Br_Taken_ID_i;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= ret_pc_q;
            inst_mem_q[wr_ptr_q] <= imem.rdata;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && (count_q == CW'(DEPTH))));
endmodule

// File: tb/tb_if_prefetch_queue.sv
// Randomised bench for if_prefetch_queue: memory model drives the bus, a monitor
// checks the delivered instruction stream against an expected-PC reference.
module tb_if_prefetch_queue;
    localparam int          W  = 32;
    localparam int          D  = 4;
    localparam logic [31:0] RP = 32'h0;

    logic        clk = 1'b0, rst = 1'b0, hazard = 1'b0, br = 1'b0;
    logic [31:0] br_addr = '0;
    logic [31:0] pc_if, inst_if;
    logic        if_valid, if_flush;

    if_prefetch_queue_if #(.WORD_LEN(W)) imem ();

    if_prefetch_queue #(.WORD_LEN(W), .DEPTH(D), .RESET_PC(RP)) dut (
        .clk(clk), .rst(rst), .hazard_detected_i(hazard), .Br_Taken_ID_i(br),
        .Br_addr_ID_i(br_addr), .imem(imem), .PC_IF_o(pc_if), .inst_IF_o(inst_if),
        .IF_valid_o(if_valid), .IF_Flush_o(if_flush));

    always #5 clk = ~clk;

    int checks = 0, failures = 0, pops = 0;
    int gnt_mode = 0;  // 0 always grant, 1 random, 2 never
    int rv_mode  = 0;  // 0 one-cycle return, 1 random delay, 2 two-cycle return

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memword(logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
    endfunction

    // Memory model: in-order responses; every granted address must follow the current stream.
    typedef struct { logic [31:0] addr; int rdy; } rsp_t;
    rsp_t        mq[$];
    logic [31:0] exp_fetch = RP;
    logic [31:0] pend_addr = '0;
    logic        pend = 1'b0;
    int          cyc = 0;

    initial begin
        imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                mq.delete();
                imem.gnt = 1'b0; imem.rvalid = 1'b0;
                exp_fetch = RP; pend = 1'b0;
            end else begin
                if (mq.size() > 0 && mq[0].rdy <= cyc && (rv_mode != 1 || $urandom_range(0, 2) != 0)) begin
                    imem.rvalid = 1'b1;
                    imem.rdata  = memword(mq[0].addr);
                    void'(mq.pop_front());
                end else begin
                    imem.rvalid = 1'b0;
                    imem.rdata  = $urandom;
                end
                case (gnt_mode)
                    0:       imem.gnt = 1'b1;
                    1:       imem.gnt = 1'($urandom_range(0, 1));
                    default: imem.gnt = 1'b0;
                endcase
                if (br) begin
                    chk("req_in_flush", 32'(imem.req), 32'd0);
                    exp_fetch = br_addr;
                    pend = 1'b0;
                end else if (imem.req) begin
                    if (pend) chk("addr_stable", imem.addr, pend_addr);
                    if (imem.gnt) begin
                        chk("fetch_addr", imem.addr, exp_fetch);
                        exp_fetch += 32'd4;
                        mq.push_back('{imem.addr, cyc + (rv_mode == 0 ? 1 : rv_mode == 2 ? 2 : 1 + $urandom_range(0, 2))});
                        pend = 1'b0;
                    end else begin
                        pend = 1'b1; pend_addr = imem.addr;
                    end
                end else begin
                    pend = 1'b0;
                end
            end
        end
    end

    // Monitor: each pop must deliver the next PC of the current stream with that PC's word.
    logic [31:0] exp_pc = RP;
    logic        flush_exp = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rst_valid", 32'(if_valid), 32'd0);
                chk("rst_req",   32'(imem.req), 32'd0);
                chk("rst_flush", 32'(if_flush), 32'd0);
                exp_pc = RP; flush_exp = 1'b0;
            end else begin
                chk("if_flush", 32'(if_flush), 32'(flush_exp));
                flush_exp = br;
                if (br) begin
                    chk("valid_in_flush", 32'(if_valid), 32'd0);
                    exp_pc = br_addr;
                end else if (if_valid && !hazard) begin
                    chk("pc_if", pc_if, exp_pc);
                    chk("inst_if", inst_if, memword(exp_pc));
                    exp_pc += 32'd4;
                    pops++;
                end
            end
        end
    end

    task automatic first_valid_latency();
        int n = 0;
        do begin @(negedge clk); n++; end while (!if_valid && n < 20);
        chk("first_valid_lat", 32'(n), 32'd3);
    endtask

    task automatic redirect(logic [31:0] a);
        @(posedge clk); #1 br = 1'b1; br_addr = a;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        first_valid_latency();
        repeat (10) @(posedge clk);

        // Long stall: the FIFO fills, requests stop, nothing is lost on release.
        #1 hazard = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("stall_req_drop", 32'(imem.req), 32'd0);
        chk("stall_valid",    32'(if_valid), 32'd1);
        @(posedge clk); #1 hazard = 1'b0;
        repeat (6) @(posedge clk);

        // Redirect with two responses outstanding.
        rv_mode = 2;
        repeat (4) @(posedge clk);
        redirect(32'h100);
        @(posedge clk); #1 br = 1'b0;
        repeat (8) @(posedge clk);
        rv_mode = 0;

        // Grant withheld: request held steady while the FIFO drains.
        gnt_mode = 2;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("nognt_drained", 32'(if_valid), 32'd0);
        chk("nognt_req",     32'(imem.req), 32'd1);
        gnt_mode = 0;
        repeat (6) @(posedge clk);

        // Back-to-back redirects.
        redirect(32'h200);
        redirect(32'h300);
        @(posedge clk); #1 br = 1'b0;
        repeat (8) @(posedge clk);

        // Reset mid-stream with a full FIFO.
        #1 hazard = 1'b1;
        repeat (6) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midrst_valid", 32'(if_valid), 32'd0);
        chk("midrst_req",   32'(imem.req), 32'd0);
        chk("midrst_flush", 32'(if_flush), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1; hazard = 1'b0;
        first_valid_latency();

        // Random traffic, stalls, redirects (including near address wrap).
        gnt_mode = 1; rv_mode = 1;
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] r;
            @(posedge clk);
            #1;
            r = $urandom;
            hazard = ($urandom_range(0, 9) < 3);
            br     = ($urandom_range(0, 19) == 0);
            br_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : (r & ~32'h3);
        end
        @(posedge clk); #1 br = 1'b0; hazard = 1'b0;
        gnt_mode = 0; rv_mode = 0;
        repeat (20) @(posedge clk);
        chk("progress", 32'(pops > 300), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
